muldiv_unit: RTL and testbench

Execute-stage multiply/divide unit that consumes the 6-bit `alucontrol` code produced by the ALU decoder for the MULT/MULTU/DIV/DIVU instructions and produces the 64-bit HI/LO result.
- Multiply completes in one extra cycle.
- Divide is a 32-iteration radix-2 restoring divider.
- The unit holds the pipeline through `stall` until the result is ready, then pulses `done`.
- It sits beside the ALU in EX; its `hi`/`lo` feed the HI/LO register write port.

---
 rtl/muldiv_unit_if.sv | 22 ++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage request/result bundle for the multiply/divide unit
interface muldiv_unit_if;
    logic        valid;
    logic        flush;
    logic [5:0]  alucontrol;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output valid, flush, alucontrol, a, b,
        input  stall, done, hi, lo
    );

    modport slave (
        input  valid, flush, alucontrol, a, b,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - MULT/MULTU/DIV/DIVU unit: one-cycle multiply, 32-step restoring divide
module muldiv_unit (
    input  logic          clk,
    input  logic          resetn,
    muldiv_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] rem;
    logic [31:0] quot;
    logic [31:0] divisor;
    logic        qneg;
    logic        rneg;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_op;
    logic        is_div;
    logic        is_signed;
    logic        start;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_diff;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] lo_fix;
    logic [31:0] hi_fix;

    // Codes 011000..011011: bit 1 selects divide, bit 0 selects unsigned.
    assign is_op     = (bus.alucontrol[5:2] == 4'b0110);
    assign is_div    = bus.alucontrol[1];
    assign is_signed = ~bus.alucontrol[0];
    assign start     = bus.valid & ~bus.flush & is_op & (state == S_IDLE);

    assign a_neg = is_signed & bus.a[31];
    assign b_neg = is_signed & bus.b[31];
    assign abs_a = a_neg ? (32'd0 - bus.a) : bus.a;
    assign abs_b = b_neg ? (32'd0 - bus.b) : bus.b;

    // Sign-extending to 64 bits lets one modulo-2^64 multiplier serve both MULT and MULTU.
    assign mul_a   = {{32{a_neg}}, bus.a};
    assign mul_b   = {{32{b_neg}}, bus.b};
    assign product = mul_a * mul_b;

    // After a successful subtract the remainder is below the divisor, so 32 stored bits suffice.
    assign rem_shift = {rem, quot[31]};
    assign rem_ge    = (rem_shift >= {1'b0, divisor});
    assign rem_diff  = rem_shift[31:0] - divisor;
    assign rem_next  = rem_ge ? rem_diff : rem_shift[31:0];
    assign quot_next = {quot[30:0], rem_ge};

    assign lo_fix = qneg ? (32'd0 - quot_next) : quot_next;
    assign hi_fix = rneg ? (32'd0 - rem_next)  : rem_next;

    assign bus.stall = start | (state == S_DIV);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            count   <= 5'd0;
            rem     <= 32'd0;
            quot    <= 32'd0;
            divisor <= 32'd0;
            qneg    <= 1'b0;
            rneg    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (!is_div) begin
                                hi_q   <= product[63:32];
                                lo_q   <= product[31:0];
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else if (bus.b == 32'd0) begin
                                hi_q   <= bus.a;
                                lo_q   <= 32'hFFFF_FFFF;
                                done_q <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                rem     <= 32'd0;
                                quot    <= abs_a;
                                divisor <= abs_b;
                                qneg    <= a_neg ^ b_neg;
                                rneg    <= a_neg;
                                count   <= 5'd0;
                                state   <= S_DIV;
                            end
                        end
                    end
                    S_DIV: begin
                        rem   <= rem_next;
                        quot  <= quot_next;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            hi_q   <= hi_fix;
                            lo_q   <= lo_fix;
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_ADD   = 6'b100000;

    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == OP_MULT) begin
            p = sx * sy;
        end else if (op == OP_MULTU) begin
            p = {32'd0, x} * {32'd0, y};
        end else if (y == 32'd0) begin
            p = {x, 32'hFFFF_FFFF};
        end else begin
            if (op == OP_DIV) begin
                q = sx / sy;
                r = sx % sy;
            end else begin
                q = longint'({32'd0, x}) / longint'({32'd0, y});
                r = longint'({32'd0, x}) % longint'({32'd0, y});
            end
            p = {r[31:0], q[31:0]};
        end
        return p;
    endfunction

    function automatic int latency(input logic [5:0] op, input logic [31:0] y);
        return ((op == OP_DIV || op == OP_DIVU) && y != 32'd0) ? 33 : 1;
    endfunction

    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [63:0] exp;
        int k;
        int st;
        exp = model(op, av, bv);
        @(negedge clk);
        bus.valid = 1'b1; bus.alucontrol = op; bus.a = av; bus.b = bv;
        #1 chk({tag, " stall@accept"}, 32'(bus.stall), 32'd1);
        st = 1;
        @(negedge clk);
        bus.valid = 1'b0;
        k = 1;
        while (bus.done !== 1'b1 && k < 40) begin
            if (bus.stall === 1'b1) st++;
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(latency(op, bv)));
        chk({tag, " stall cycles"}, 32'(st), 32'(latency(op, bv)));
        chk({tag, " hi"}, bus.hi, exp[63:32]);
        chk({tag, " lo"}, bus.lo, exp[31:0]);
        chk({tag, " stall@done"}, 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk({tag, " done width"}, 32'(bus.done), 32'd0);
        last_hi = exp[63:32];
        last_lo = exp[31:0];
    endtask

    initial begin
        logic [63:0] exp;
        logic [5:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int k;
        int saw_done;

        errors = 0;
        checks = 0;
        resetn = 1'b0;
        bus.valid = 1'b0; bus.flush = 1'b0; bus.alucontrol = 6'd0; bus.a = 32'd0; bus.b = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset hi", bus.hi, 32'd0);
        chk("reset lo", bus.lo, 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        resetn = 1'b1;

        run_op("mult neg", OP_MULT, 32'hFFFF_FFFE, 32'd3);
        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu by0", OP_DIVU, 32'd5, 32'd0);
        run_op("div by0", OP_DIV, 32'hFFFF_FFF0, 32'd0);

        // Flush a DIVU after ten iterations.
        @(negedge clk);
        bus.valid = 1'b1; bus.alucontrol = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("flush stall before", 32'(bus.stall), 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush stall drop", 32'(bus.stall), 32'd0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done++;
            @(negedge clk);
        end
        chk("flush no done", 32'(saw_done), 32'd0);
        chk("flush hi kept", bus.hi, last_hi);
        chk("flush lo kept", bus.lo, last_lo);
        run_op("mult after flush", OP_MULT, 32'd2, 32'd3);

        // DIVU then MULTU with valid held high throughout.
        @(negedge clk);
        bus.valid = 1'b1; bus.alucontrol = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd9;
        @(negedge clk);
        bus.alucontrol = OP_MULTU; bus.a = 32'h1234_5678; bus.b = 32'h0000_1000;
        k = 1;
        while (bus.done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        exp = model(OP_DIVU, 32'd1000, 32'd9);
        chk("b2b div latency", 32'(k), 32'd33);
        chk("b2b div lo", bus.lo, exp[31:0]);
        chk("b2b div hi", bus.hi, exp[63:32]);
        chk("b2b stall@done", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("b2b mul accept stall", 32'(bus.stall), 32'd1);
        chk("b2b mul accept done", 32'(bus.done), 32'd0);
        @(negedge clk);
        bus.valid = 1'b0;
        exp = model(OP_MULTU, 32'h1234_5678, 32'h0000_1000);
        chk("b2b mul done", 32'(bus.done), 32'd1);
        chk("b2b mul hi", bus.hi, exp[63:32]);
        chk("b2b mul lo", bus.lo, exp[31:0]);
        last_hi = exp[63:32];
        last_lo = exp[31:0];

        // Non-muldiv code is ignored.
        @(negedge clk);
        bus.valid = 1'b1; bus.alucontrol = OP_ADD; bus.a = 32'd9; bus.b = 32'd9;
        #1 chk("add stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        chk("add done", 32'(bus.done), 32'd0);
        chk("add stall next", 32'(bus.stall), 32'd0);
        chk("add hi kept", bus.hi, last_hi);
        bus.valid = 1'b0;

        for (int i = 0; i < 24; i++) begin
            rop = OP_MULT + 6'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op("random", rop, ra, rb);
        end

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.valid = 1'b1; bus.alucontrol = OP_DIV; bus.a = 32'd12345; bus.b = 32'd77;
        @(negedge clk);
        bus.valid = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midreset hi", bus.hi, 32'd0);
        chk("midreset lo", bus.lo, 32'd0);
        chk("midreset stall", 32'(bus.stall), 32'd0);
        chk("midreset done", 32'(bus.done), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op("after reset", OP_DIVU, 32'd77, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
